mem_bus_arbiter: RTL and testbench

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

---
 rtl/mem_bus_arbiter.sv | 148 ++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// Two-requester round-robin arbiter for a single memory master port.
// Ports: clk/rst, req/we/addr/wdata per requester in, gnt/done/err/rdata per
// requester out, mem_addr/mem_wdata/mem_we to memory, mem_rdata/mem_ready in.
module mem_bus_arbiter #(
    parameter int LENGTH  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              we0,
    input  logic [LENGTH-1:0] addr0,
    input  logic [LENGTH-1:0] wdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [LENGTH-1:0] addr1,
    input  logic [LENGTH-1:0] wdata1,
    output logic              gnt0,
    output logic              done0,
    output logic              err0,
    output logic [LENGTH-1:0] rdata0,
    output logic              gnt1,
    output logic              done1,
    output logic              err1,
    output logic [LENGTH-1:0] rdata1,
    output logic [LENGTH-1:0] mem_addr,
    output logic [LENGTH-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [LENGTH-1:0] mem_rdata,
    input  logic              mem_ready
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic              ptr;
    logic              owner;
    logic              cap_we;
    logic              aborted;
    logic [CW-1:0]     cnt;
    logic [LENGTH-1:0] addr_q;
    logic [LENGTH-1:0] wdata_q;
    logic [LENGTH-1:0] rdata0_q;
    logic [LENGTH-1:0] rdata1_q;

    logic any_req;
    logic win;
    logic tmo;

    assign any_req = req0 | req1;
    // Contention goes to the pointer; otherwise the lone requester wins.
    assign win     = (req0 & req1) ? ptr : req1;
    assign tmo     = (cnt == CW'(TIMEOUT - 1));

    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign rdata0    = rdata0_q;
    assign rdata1    = rdata1_q;

    always_comb begin
        state_nx = state;
        gnt0     = 1'b0;
        gnt1     = 1'b0;
        done0    = 1'b0;
        done1    = 1'b0;
        err0     = 1'b0;
        err1     = 1'b0;
        mem_we   = 1'b0;
        unique case (state)
            IDLE: begin
                // Grant is a same-cycle pulse; suppressed while in reset.
                if (any_req && !rst) begin
                    gnt0     = ~win;
                    gnt1     = win;
                    state_nx = ACCESS;
                end
            end
            ACCESS: begin
                mem_we = cap_we;
                if (mem_ready || tmo) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                done0    = ~owner;
                done1    = owner;
                err0     = ~owner & aborted;
                err1     = owner & aborted;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= 1'b0;
            owner    <= 1'b0;
            cap_we   <= 1'b0;
            aborted  <= 1'b0;
            cnt      <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state <= state_nx;
            unique case (state)
                IDLE: begin
                    if (any_req) begin
                        owner   <= win;
                        ptr     <= ~win;
                        cap_we  <= win ? we1 : we0;
                        addr_q  <= win ? addr1 : addr0;
                        wdata_q <= win ? wdata1 : wdata0;
                        cnt     <= '0;
                        aborted <= 1'b0;
                    end
                end
                ACCESS: begin
                    if (mem_ready) begin
                        // Stores leave the owner's read data untouched.
                        if (!cap_we) begin
                            if (owner) rdata1_q <= mem_rdata;
                            else       rdata0_q <= mem_rdata;
                        end
                    end else if (tmo) begin
                        aborted <= 1'b1;
                        if (owner) rdata1_q <= '0;
                        else       rdata0_q <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Randomized self-checking bench for mem_bus_arbiter against a
// transaction-level model of round-robin grant, latency and read data.
module tb_mem_bus_arbiter;

    localparam int W  = 32;
    localparam int TO = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0, we0, req1, we1;
    logic [W-1:0] addr0, wdata0, addr1, wdata1;
    logic         gnt0, done0, err0, gnt1, done1, err1;
    logic [W-1:0] rdata0, rdata1;
    logic [W-1:0] mem_addr, mem_wdata, mem_rdata;
    logic         mem_we, mem_ready;

    mem_bus_arbiter #(.LENGTH(W), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .gnt0(gnt0), .done0(done0), .err0(err0), .rdata0(rdata0),
        .gnt1(gnt1), .done1(done1), .err1(err1), .rdata1(rdata1),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    int           n_vec = 0;
    int           n_err = 0;
    bit           pend[2];
    logic         t_we[2];
    logic [W-1:0] t_addr[2];
    logic [W-1:0] t_wdata[2];
    logic [W-1:0] m_rd[2];
    int           m_ptr;

    task automatic chk(input string tag, input logic [W-1:0] got,
                       input logic [W-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive_reqs();
        req0 = pend[0]; we0 = t_we[0]; addr0 = t_addr[0]; wdata0 = t_wdata[0];
        req1 = pend[1]; we1 = t_we[1]; addr1 = t_addr[1]; wdata1 = t_wdata[1];
    endtask

    task automatic new_req(input int i, input logic we,
                           input logic [W-1:0] a, input logic [W-1:0] d);
        pend[i] = 1'b1; t_we[i] = we; t_addr[i] = a; t_wdata[i] = d;
    endtask

    // Entered #1 after a rising edge with the DUT idle; returns likewise.
    // k: ACCESS cycle index at which mem_ready rises (>= TO means never).
    task automatic txn(input int k, input bit poke, input logic [W-1:0] rd_val);
        int           w, o, n_acc;
        bit           e;
        logic         gwe;
        logic [W-1:0] ga, gwd, exp_rd;
        drive_reqs();
        w = (pend[0] && pend[1]) ? m_ptr : (pend[1] ? 1 : 0);
        o = 1 - w;
        m_ptr = o;
        @(negedge clk);
        chk("gnt0", gnt0, (w == 0));
        chk("gnt1", gnt1, (w == 1));
        ga = t_addr[w]; gwd = t_wdata[w]; gwe = t_we[w];
        n_acc = (k < TO) ? k + 1 : TO;
        e = (k >= TO);
        exp_rd = m_rd[w];
        @(posedge clk); #1;
        pend[w] = 1'b0;
        if (poke) begin
            t_addr[w] = '0;
            t_wdata[w] = ~gwd;
        end
        drive_reqs();
        for (int c = 0; c < n_acc; c++) begin
            if (c > 0) begin
                @(posedge clk); #1;
            end
            mem_ready = (c == k);
            mem_rdata = (c == k) ? rd_val : $urandom;
            if (c == k && !gwe) exp_rd = rd_val;
            @(negedge clk);
            chk("acc_addr", mem_addr, ga);
            chk("acc_we", mem_we, gwe);
            if (gwe) chk("acc_wdata", mem_wdata, gwd);
            chk("acc_gnt", {gnt1, gnt0}, 2'b00);
            chk("acc_done", {done1, done0}, 2'b00);
        end
        if (e) exp_rd = '0;
        m_rd[w] = exp_rd;
        @(posedge clk); #1;
        mem_ready = 1'b0;
        @(negedge clk);
        chk("done_own", w ? done1 : done0, 1'b1);
        chk("done_oth", w ? done0 : done1, 1'b0);
        chk("err_own", w ? err1 : err0, e);
        chk("err_oth", w ? err0 : err1, 1'b0);
        chk("done_we", mem_we, 1'b0);
        chk("done_addr", mem_addr, ga);
        chk("done_gnt", {gnt1, gnt0}, 2'b00);
        chk("rdata_own", w ? rdata1 : rdata0, m_rd[w]);
        chk("rdata_oth", w ? rdata0 : rdata1, m_rd[o]);
        @(posedge clk); #1;
    endtask

    initial begin
        pend[0] = 0; pend[1] = 0;
        t_we[0] = 0; t_we[1] = 0;
        t_addr[0] = '0; t_addr[1] = '0;
        t_wdata[0] = '0; t_wdata[1] = '0;
        m_rd[0] = '0; m_rd[1] = '0;
        m_ptr = 0;
        mem_ready = 0; mem_rdata = '0;
        rst = 1'b1;
        new_req(0, 1'b0, 32'h1234_0000, 32'h0);
        drive_reqs();
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_gnt", {gnt1, gnt0}, 2'b00);
        chk("rst_done", {done1, done0, err1, err0}, 4'h0);
        chk("rst_we", mem_we, 1'b0);
        chk("rst_addr", mem_addr, '0);
        chk("rst_wdata", mem_wdata, '0);
        chk("rst_rdata0", rdata0, '0);
        chk("rst_rdata1", rdata1, '0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Contention from reset: order 0,1,0,1.
        new_req(1, 1'b0, 32'h2000_0000, 32'h0);
        for (int r = 0; r < 4; r++) begin
            if (!pend[0]) new_req(0, 1'b0, 32'h1000_0000 + r, 32'h0);
            if (!pend[1]) new_req(1, 1'b0, 32'h2000_0000 + r, 32'h0);
            txn(0, 0, $urandom);
        end
        pend[1] = 0;
        txn(0, 0, $urandom);

        // Basic load.
        new_req(0, 1'b0, 32'h1001_0004, 32'h0);
        txn(0, 0, 32'hDEAD_BEEF);
        // Store with three wait cycles; rdata1 must not change.
        new_req(1, 1'b1, 32'h1001_0020, 32'h55);
        txn(3, 1, 32'hFFFF_FFFF);
        // Timeout abort with operands changed after grant.
        new_req(0, 1'b0, 32'h1001_0008, 32'h0);
        txn(TO + 4, 1, 32'hCAFE_F00D);
        // Ready on the last permitted cycle still completes normally.
        new_req(0, 1'b0, 32'h1001_000C, 32'h0);
        txn(TO - 1, 0, 32'h0BAD_CAFE);

        // Reset in the middle of an access.
        new_req(0, 1'b1, 32'h1001_0040, 32'h77);
        drive_reqs();
        @(negedge clk);
        chk("mr_gnt0", gnt0, 1'b1);
        @(posedge clk); #1;
        pend[0] = 0;
        drive_reqs();
        rst = 1'b1;
        @(negedge clk);
        chk("mr_acc_we", mem_we, 1'b1);
        @(posedge clk); #1;
        rst = 1'b0;
        m_ptr = 0; m_rd[0] = '0; m_rd[1] = '0;
        @(negedge clk);
        chk("mr_we", mem_we, 1'b0);
        chk("mr_addr", mem_addr, '0);
        chk("mr_wdata", mem_wdata, '0);
        chk("mr_flags", {gnt1, gnt0, done1, done0, err1, err0}, 6'h0);
        chk("mr_rdata", {rdata1, rdata0}, 64'h0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("mr_quiet", {done1, done0, err1, err0, mem_we}, 5'h0);
        @(posedge clk); #1;

        // Random traffic.
        for (int n = 0; n < 250; n++) begin
            int k;
            for (int i = 0; i < 2; i++)
                if (!pend[i] && $urandom_range(0, 1) == 1)
                    new_req(i, 1'($urandom_range(0, 1)), $urandom, $urandom);
            if (!pend[0] && !pend[1]) begin
                int j;
                j = $urandom_range(0, 1);
                new_req(j, 1'($urandom_range(0, 1)), $urandom, $urandom);
            end
            k = ($urandom_range(0, 7) == 0) ? $urandom_range(TO - 1, TO + 3)
                                            : $urandom_range(0, 5);
            txn(k, 1'($urandom_range(0, 1)), $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Mutual exclusion of the per-requester pulses, sampled every cycle.
    always @(negedge clk) begin
        if (!rst && ((gnt0 && gnt1) || (done0 && done1) || (err0 && err1))) begin
            n_err++;
            $display("FAIL excl: got gnt=%b%b done=%b%b err=%b%b required one-hot",
                     gnt1, gnt0, done1, done0, err1, err0);
        end
    end

endmodule
